// File: rtl/mac_addr_extract.sv
// mac_addr_extract: captures the destination and source MAC addresses from a
// framed ingress beat stream, reduces each to a learning-table address
// (truncation or XOR-fold) and presents both on a valid/ready result register.
// Short frames raise a one-cycle oerr pulse. A completed result that cannot be
// stored because the consumer is stalled raises a one-cycle ooverflow pulse.
module mac_addr_extract #(
    parameter int pDATA_WIDTH = 8,
    parameter int pMAC_WIDTH  = 48,
    parameter int pADDR_WIDTH = 14,
    parameter int pHASH_MODE  = 0
) (
    input  logic                   iclk,
    input  logic                   irst_n,
    input  logic [pDATA_WIDTH-1:0] idata,
    input  logic                   ivalid,
    input  logic                   isof,
    input  logic                   ieof,
    output logic [pADDR_WIDTH-1:0] oda_addr,
    output logic [pADDR_WIDTH-1:0] osa_addr,
    output logic                   omcast,
    output logic                   ovalid,
    input  logic                   iready,
    output logic                   oerr,
    output logic                   ooverflow
);

    localparam int N    = pMAC_WIDTH / pDATA_WIDTH;
    localparam int CW   = (N > 1) ? $clog2(N) : 1;
    localparam int CH   = (pMAC_WIDTH + pADDR_WIDTH - 1) / pADDR_WIDTH;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    generate
        if ((pMAC_WIDTH % pDATA_WIDTH) != 0) begin : g_bad_beat_width
            $error("mac_addr_extract: pMAC_WIDTH must be a multiple of pDATA_WIDTH");
        end
        if ((pADDR_WIDTH < 1) || (pADDR_WIDTH > pMAC_WIDTH)) begin : g_bad_addr_width
            $error("mac_addr_extract: pADDR_WIDTH must lie in 1..pMAC_WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DA       = 2'd1,
        ST_SA       = 2'd2,
        ST_WAIT_EOF = 2'd3
    } state_t;

    // Shift one beat into the LSB end of an address, oldest beat ends up in the MSBs.
    function automatic logic [pMAC_WIDTH-1:0] shift_in(input logic [pMAC_WIDTH-1:0] old,
                                                       input logic [pDATA_WIDTH-1:0] d);
        return pMAC_WIDTH'({old, d});
    endfunction

    // Table address: low bits of the MAC, or XOR of all pADDR_WIDTH-bit chunks
    // with the top chunk zero-padded.
    function automatic logic [pADDR_WIDTH-1:0] hash_f(input logic [pMAC_WIDTH-1:0] mac);
        logic [CH*pADDR_WIDTH-1:0] pad;
        logic [pADDR_WIDTH-1:0]    acc;
        pad = {(CH*pADDR_WIDTH){1'b0}};
        pad[pMAC_WIDTH-1:0] = mac;
        acc = {pADDR_WIDTH{1'b0}};
        for (int k = 0; k < CH; k++) begin
            acc = acc ^ pad[k*pADDR_WIDTH +: pADDR_WIDTH];
        end
        if (pHASH_MODE == 1) begin
            return acc;
        end else begin
            return pad[pADDR_WIDTH-1:0];
        end
    endfunction

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [pMAC_WIDTH-1:0]  da_q, da_d;
    logic [pMAC_WIDTH-1:0]  sa_q, sa_d;
    logic [pADDR_WIDTH-1:0] oda_q, oda_d;
    logic [pADDR_WIDTH-1:0] osa_q, osa_d;
    logic                   omcast_q, omcast_d;
    logic                   ovalid_q, ovalid_d;
    logic                   oerr_q, ooverflow_q, ooverflow_d;
    logic                   err_s, done_s;
    logic [pMAC_WIDTH-1:0]  sa_full_s;

    // The SA as it stands once the current beat is included (used on completion).
    assign sa_full_s = shift_in(sa_q, idata);

    // Frame parser: next state, beat counter, address shift registers, error/done strobes.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        da_d    = da_q;
        sa_d    = sa_q;
        err_s   = 1'b0;
        done_s  = 1'b0;
        if (ivalid) begin
            if (isof) begin
                // A start beat always restarts; it is an error only if it cuts
                // a frame short (or is itself the end of the frame).
                if (ieof) begin
                    err_s   = 1'b1;
                    state_d = ST_IDLE;
                    cnt_d   = {CW{1'b0}};
                end else begin
                    err_s = (state_q == ST_DA) || (state_q == ST_SA);
                    da_d  = shift_in({pMAC_WIDTH{1'b0}}, idata);
                    if (cnt_q == cnt_q && LAST == {CW{1'b0}}) begin
                        state_d = ST_SA;
                        cnt_d   = {CW{1'b0}};
                    end else begin
                        state_d = ST_DA;
                        cnt_d   = CW'(1);
                    end
                end
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_d = ST_IDLE;
                    end
                    ST_DA: begin
                        da_d = shift_in(da_q, idata);
                        if (ieof) begin
                            err_s   = 1'b1;
                            state_d = ST_IDLE;
                            cnt_d   = {CW{1'b0}};
                        end else if (cnt_q == LAST) begin
                            state_d = ST_SA;
                            cnt_d   = {CW{1'b0}};
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                    ST_SA: begin
                        sa_d = sa_full_s;
                        if (cnt_q == LAST) begin
                            done_s  = 1'b1;
                            cnt_d   = {CW{1'b0}};
                            state_d = ieof ? ST_IDLE : ST_WAIT_EOF;
                        end else if (ieof) begin
                            err_s   = 1'b1;
                            state_d = ST_IDLE;
                            cnt_d   = {CW{1'b0}};
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                    ST_WAIT_EOF: begin
                        if (ieof) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_WAIT_EOF;
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                        cnt_d   = {CW{1'b0}};
                    end
                endcase
            end
        end else begin
            state_d = state_q;
        end
    end

    // Result register: load on completion unless a stalled result is pending.
    always_comb begin
        oda_d       = oda_q;
        osa_d       = osa_q;
        omcast_d    = omcast_q;
        ovalid_d    = ovalid_q;
        ooverflow_d = 1'b0;
        if (done_s) begin
            if (ovalid_q && !iready) begin
                ooverflow_d = 1'b1;
            end else begin
                oda_d    = hash_f(da_q);
                osa_d    = hash_f(sa_full_s);
                omcast_d = da_q[pMAC_WIDTH-pDATA_WIDTH];
                ovalid_d = 1'b1;
            end
        end else if (ovalid_q && iready) begin
            ovalid_d = 1'b0;
        end else begin
            ovalid_d = ovalid_q;
        end
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= {CW{1'b0}};
            da_q        <= {pMAC_WIDTH{1'b0}};
            sa_q        <= {pMAC_WIDTH{1'b0}};
            oda_q       <= {pADDR_WIDTH{1'b0}};
            osa_q       <= {pADDR_WIDTH{1'b0}};
            omcast_q    <= 1'b0;
            ovalid_q    <= 1'b0;
            oerr_q      <= 1'b0;
            ooverflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            da_q        <= da_d;
            sa_q        <= sa_d;
            oda_q       <= oda_d;
            osa_q       <= osa_d;
            omcast_q    <= omcast_d;
            ovalid_q    <= ovalid_d;
            oerr_q      <= err_s;
            ooverflow_q <= ooverflow_d;
        end
    end

    assign oda_addr  = oda_q;
    assign osa_addr  = osa_q;
    assign omcast    = omcast_q;
    assign ovalid    = ovalid_q;
    assign oerr      = oerr_q;
    assign ooverflow = ooverflow_q;

endmodule

// File: tb/tb_mac_addr_extract.sv
// Bench for mac_addr_extract: one truncating and one XOR-folding instance share
// the stimulus; each has its own scoreboard queue of expected results.
module tb_mac_addr_extract;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  idata;
    logic        ivalid, isof, ieof, iready;
    logic [13:0] oda0, osa0, oda1, osa1;
    logic        omc0, ovalid0, oerr0, oovf0;
    logic        omc1, ovalid1, oerr1, oovf1;

    always #5 clk = ~clk;

    mac_addr_extract #(.pDATA_WIDTH(8), .pMAC_WIDTH(48), .pADDR_WIDTH(14), .pHASH_MODE(0)) u_trunc (
        .iclk(clk), .irst_n(rst_n), .idata(idata), .ivalid(ivalid), .isof(isof), .ieof(ieof),
        .oda_addr(oda0), .osa_addr(osa0), .omcast(omc0), .ovalid(ovalid0), .iready(iready),
        .oerr(oerr0), .ooverflow(oovf0));

    mac_addr_extract #(.pDATA_WIDTH(8), .pMAC_WIDTH(48), .pADDR_WIDTH(14), .pHASH_MODE(1)) u_fold (
        .iclk(clk), .irst_n(rst_n), .idata(idata), .ivalid(ivalid), .isof(isof), .ieof(ieof),
        .oda_addr(oda1), .osa_addr(osa1), .omcast(omc1), .ovalid(ovalid1), .iready(iready),
        .oerr(oerr1), .ooverflow(oovf1));

    typedef struct packed {
        logic [13:0] da0, sa0, da1, sa1;
        logic        mc;
    } exp_t;

    typedef struct {
        logic [47:0] da, sa;
        int          eof_at;
        bit          ok;
        exp_t        e;
    } vec_t;

    exp_t q0[$];
    exp_t q1[$];
    int n_checks = 0;
    int n_fail   = 0;
    int err0 = 0, err1 = 0, ovf0 = 0, ovf1 = 0, xfer0 = 0, xfer1 = 0;

    // Reference reduction: bit i of the MAC lands in address bit i mod 14.
    function automatic logic [13:0] ref_hash(input logic [47:0] mac, input bit fold);
        logic [13:0] r;
        r = 14'd0;
        if (!fold) return mac[13:0];
        for (int i = 0; i < 48; i++) r[i % 14] = r[i % 14] ^ mac[i];
        return r;
    endfunction

    function automatic exp_t mk_exp(input logic [47:0] da, input logic [47:0] sa);
        exp_t e;
        e.da0 = ref_hash(da, 1'b0);
        e.sa0 = ref_hash(sa, 1'b0);
        e.da1 = ref_hash(da, 1'b1);
        e.sa1 = ref_hash(sa, 1'b1);
        e.mc  = da[40];
        return e;
    endfunction

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        ivalid = 1'b0; isof = 1'b0; ieof = 1'b0;
        repeat (n) cycle();
    endtask

    // Drive nbeats beats of a frame; optional random ivalid gaps carrying junk
    // flags; optionally push the expectation and raise iready on the completing beat.
    task automatic send(input logic [47:0] da, input logic [47:0] sa, input int nbeats,
                        input int eof_at, input bit gaps, input bit push, input bit rdy_last);
        exp_t e;
        e = mk_exp(da, sa);
        for (int b = 0; b < nbeats; b++) begin
            if (gaps) begin
                while ($urandom_range(0, 2) == 0) begin
                    ivalid = 1'b0;
                    isof   = 1'($urandom_range(0, 1));
                    ieof   = 1'($urandom_range(0, 1));
                    idata  = 8'($urandom);
                    cycle();
                end
            end
            if (b < 6)       idata = da[8*(5-b) +: 8];
            else if (b < 12) idata = sa[8*(11-b) +: 8];
            else             idata = 8'($urandom);
            isof   = (b == 0);
            ieof   = (b == eof_at);
            ivalid = 1'b1;
            if (b == 11 && push) begin
                q0.push_back(e);
                q1.push_back(e);
            end
            if (b == 11 && rdy_last) iready = 1'b1;
            cycle();
        end
        ivalid = 1'b0; isof = 1'b0; ieof = 1'b0;
    endtask

    // Output monitor: counts pulses and checks every transfer against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (oerr0) err0++;
            if (oerr1) err1++;
            if (oovf0) ovf0++;
            if (oovf1) ovf1++;
            if (ovalid0 && iready) begin
                xfer0++;
                if (q0.size() == 0) chk("unexpected_xfer_trunc", 48'd1, 48'd0);
                else begin
                    exp_t e;
                    e = q0.pop_front();
                    chk("da_trunc", 48'(oda0), 48'(e.da0));
                    chk("sa_trunc", 48'(osa0), 48'(e.sa0));
                    chk("mcast_trunc", 48'(omc0), 48'(e.mc));
                end
            end
            if (ovalid1 && iready) begin
                xfer1++;
                if (q1.size() == 0) chk("unexpected_xfer_fold", 48'd1, 48'd0);
                else begin
                    exp_t e;
                    e = q1.pop_front();
                    chk("da_fold", 48'(oda1), 48'(e.da1));
                    chk("sa_fold", 48'(osa1), 48'(e.sa1));
                    chk("mcast_fold", 48'(omc1), 48'(e.mc));
                end
            end
        end
    end

    initial begin
        vec_t vt[7];
        int e0, e1, x0, x1, v0, v1;
        logic [47:0] a_da, a_sa, b_da, b_sa;

        vt[0] = '{48'h001122334455, 48'h020000000001, 11, 1'b1,
                  '{14'h0455, 14'h0001, 14'h0D8A, 14'h2001, 1'b0}};
        vt[1] = '{48'h01AABBCCDDEE, 48'h123456789ABC, 11, 1'b1,
                  mk_exp(48'h01AABBCCDDEE, 48'h123456789ABC)};
        vt[2] = '{48'hFFFFFFFFFFFF, 48'h000000000000, 20, 1'b1,
                  '{14'h3FFF, 14'h0000, 14'h3FC0, 14'h0000, 1'b1}};
        vt[3] = '{48'h0A0B0C0D0E0F, 48'h101112131415, 7, 1'b0,
                  mk_exp(48'h0A0B0C0D0E0F, 48'h101112131415)};
        vt[4] = '{48'h0A0B0C0D0E0F, 48'h101112131415, 5, 1'b0,
                  mk_exp(48'h0A0B0C0D0E0F, 48'h101112131415)};
        vt[5] = '{48'h0A0B0C0D0E0F, 48'h101112131415, 0, 1'b0,
                  mk_exp(48'h0A0B0C0D0E0F, 48'h101112131415)};
        vt[6] = '{48'h5A5A00FFC3C3, 48'h0000DEADBEEF, 11, 1'b1,
                  mk_exp(48'h5A5A00FFC3C3, 48'h0000DEADBEEF)};

        rst_n = 1'b0; idata = 8'd0; ivalid = 1'b0; isof = 1'b0; ieof = 1'b0; iready = 1'b1;
        repeat (3) cycle();
        chk("rst_ovalid", 48'({ovalid0, ovalid1}), 48'd0);
        chk("rst_addr", 48'({oda0, osa0, oda1, osa1}), 48'd0);
        chk("rst_flags", 48'({omc0, omc1, oerr0, oerr1, oovf0, oovf1}), 48'd0);
        rst_n = 1'b1;
        cycle();

        // Table-driven frames with the consumer always ready.
        for (int i = 0; i < 7; i++) begin
            e0 = err0; e1 = err1; x0 = xfer0; x1 = xfer1;
            if (vt[i].ok) begin
                q0.push_back(vt[i].e);
                q1.push_back(vt[i].e);
            end
            send(vt[i].da, vt[i].sa, vt[i].eof_at + 1, vt[i].eof_at, 1'b0, 1'b0, 1'b0);
            idle(4);
            chk($sformatf("vec%0d_err_trunc", i), 48'(err0 - e0), vt[i].ok ? 48'd0 : 48'd1);
            chk($sformatf("vec%0d_err_fold", i), 48'(err1 - e1), vt[i].ok ? 48'd0 : 48'd1);
            chk($sformatf("vec%0d_xfer", i), 48'({16'(xfer0 - x0), 16'(xfer1 - x1)}),
                vt[i].ok ? 48'h0000_0001_0001 : 48'd0);
            chk($sformatf("vec%0d_ovalid_low", i), 48'({ovalid0, ovalid1}), 48'd0);
        end

        // New isof in the middle of the SA: error, then the new frame completes.
        a_da = 48'h0102030405FF; a_sa = 48'hA1A2A3A4A5A6;
        b_da = 48'hC0FFEE123456; b_sa = 48'h7766554433AB;
        e0 = err0; x0 = xfer0;
        send(a_da, a_sa, 8, -1, 1'b0, 1'b0, 1'b0);
        send(b_da, b_sa, 12, 11, 1'b0, 1'b1, 1'b0);
        idle(4);
        chk("restart_err", 48'(err0 - e0), 48'd1);
        chk("restart_xfer", 48'(xfer0 - x0), 48'd1);

        // Stalled consumer, two frames back-to-back: second result dropped.
        iready = 1'b0;
        e0 = ovf0; e1 = ovf1; x0 = xfer0;
        send(a_da, a_sa, 12, 11, 1'b0, 1'b1, 1'b0);
        send(b_da, b_sa, 12, 11, 1'b0, 1'b0, 1'b0);
        idle(3);
        chk("ovf_pulse_trunc", 48'(ovf0 - e0), 48'd1);
        chk("ovf_pulse_fold", 48'(ovf1 - e1), 48'd1);
        chk("ovf_hold_valid", 48'({ovalid0, ovalid1}), 48'b11);
        chk("ovf_hold_da", 48'(oda1), 48'(ref_hash(a_da, 1'b1)));
        iready = 1'b1;
        idle(3);
        chk("ovf_one_xfer", 48'(xfer0 - x0), 48'd1);
        chk("ovf_drain", 48'({ovalid0, ovalid1}), 48'd0);

        // Completion in the same cycle as a pop: both results delivered, no overflow.
        iready = 1'b0;
        e0 = ovf0; x0 = xfer0; x1 = xfer1;
        send(a_da, a_sa, 12, 11, 1'b0, 1'b1, 1'b0);
        send(b_da, b_sa, 12, 11, 1'b0, 1'b1, 1'b1);
        idle(3);
        chk("samecyc_no_ovf", 48'(ovf0 - e0), 48'd0);
        chk("samecyc_xfers", 48'({16'(xfer0 - x0), 16'(xfer1 - x1)}), 48'h0000_0002_0002);

        // Long frame with random ivalid gaps; trailing beats must not matter.
        e0 = err0; x0 = xfer0;
        send(48'h001122334455, 48'h020000000001, 64, 63, 1'b1, 1'b1, 1'b0);
        idle(4);
        chk("gaps_err", 48'(err0 - e0), 48'd0);
        chk("gaps_xfer", 48'(xfer0 - x0), 48'd1);

        // Asynchronous reset mid-frame with a held result, then realignment on isof.
        iready = 1'b0;
        send(a_da, a_sa, 12, 11, 1'b0, 1'b0, 1'b0);
        send(b_da, b_sa, 6, -1, 1'b0, 1'b0, 1'b0);
        v0 = int'(ovalid0); v1 = int'(ovalid1);
        chk("pre_reset_valid", 48'({v0[0], v1[0]}), 48'b11);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid", 48'({ovalid0, ovalid1}), 48'd0);
        chk("midrst_addr", 48'({oda0, osa0, oda1, osa1}), 48'd0);
        cycle();
        rst_n = 1'b1;
        iready = 1'b1;
        e0 = err0; e1 = err1; x0 = xfer0;
        for (int b = 0; b < 7; b++) begin
            idata = 8'($urandom); isof = 1'b0; ieof = (b == 3); ivalid = 1'b1;
            cycle();
        end
        send(b_da, b_sa, 12, 11, 1'b0, 1'b1, 1'b0);
        idle(4);
        chk("postrst_err", 48'({16'(err0 - e0), 16'(err1 - e1)}), 48'd0);
        chk("postrst_xfer", 48'(xfer0 - x0), 48'd1);

        chk("sb_empty_trunc", 48'(q0.size()), 48'd0);
        chk("sb_empty_fold", 48'(q1.size()), 48'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
